// File: rtl/timecounter_pkg.sv
// timecounter_pkg: shared encodings for the time-of-day counter.
//   - edit field select codes (sel input)
//   - hold-to-repeat FSM states
//   - hour12(): 24 h internal hour to 1..12 display hour
package timecounter_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_SEC  = 2'b01;
    localparam logic [1:0] SEL_MIN  = 2'b10;
    localparam logic [1:0] SEL_HOUR = 2'b11;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_WAIT   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Hour 0 and 12 both display as 12. Values above 23 are folded as well,
    // so a non-24 MOD_H still gives a value in 1..12.
    function automatic logic [4:0] hour12(input logic [4:0] h);
        logic [4:0] r;
        if (h >= 5'd24)
            r = h - 5'd24;
        else if (h >= 5'd12)
            r = h - 5'd12;
        else
            r = h;
        return (r == 5'd0) ? 5'd12 : r;
    endfunction

endpackage

// File: rtl/timecounter_rpt_field.sv
// tc_field: generic modulo-MOD up/down register.
//   clk, rst_n : clock, asynchronous active-low reset (q -> 0)
//   carry_in   : running increment from the lower field or the tick
//   en_up      : edit step up   (wraps MOD-1 -> 0, no carry out)
//   en_dn      : edit step down (wraps 0 -> MOD-1, no carry out)
//   q          : current value 0..MOD-1
//   wrap_out   : carry_in is wrapping this field to 0 this cycle
module tc_field #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_up,
    input  logic         en_dn,
    input  logic         carry_in,
    output logic [W-1:0] q,
    output logic         wrap_out
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    logic [W-1:0] q_reg;

    // Only the running carry propagates; edits wrap silently.
    assign wrap_out = carry_in & (q_reg == TOP);
    assign q        = q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (carry_in | en_up) begin
            q_reg <= (q_reg == TOP) ? '0 : q_reg + W'(1);
        end else if (en_dn) begin
            q_reg <= (q_reg == '0) ? TOP : q_reg - W'(1);
        end
    end

endmodule

// File: rtl/timecounter_rpt.sv
// timecounter_rpt: HH:MM:SS time-of-day counter with hold-to-repeat editing.
//   clk, rst_n       : clock, asynchronous active-low reset
//   tick1Hz          : 1 Hz square wave, rising edge advances time when running
//   freeze           : 1 = time halted, editing enabled
//   inc, dec         : debounced edit buttons (levels)
//   sel              : edit field (none / seconds / minutes / hours)
//   mode12           : 1 = 12 h display on hh/pm
//   ss, mm, hh, pm   : display outputs
//   dayroll          : one-cycle pulse on a running wrap to 00:00:00
// Optional (macro TIMECOUNTER_ALARM_EN):
//   alarm_on, alarm_hh (24 h), alarm_mm : alarm setting
//   alarm_hit        : one-cycle pulse when a running tick lands on hh:mm:00
module timecounter_rpt
    import timecounter_pkg::*;
#(
    parameter int MOD_S        = 60,
    parameter int MOD_M        = 60,
    parameter int MOD_H        = 24,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int RPT_W        = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick1Hz,
    input  logic       freeze,
    input  logic       inc,
    input  logic       dec,
    input  logic [1:0] sel,
    input  logic       mode12,
    output logic [5:0] ss,
    output logic [5:0] mm,
    output logic [4:0] hh,
    output logic       pm,
    output logic       dayroll
`ifdef TIMECOUNTER_ALARM_EN
    ,
    input  logic       alarm_on,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    output logic       alarm_hit
`endif
);

    localparam logic [RPT_W-1:0] DELAY_LD = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RATE_LD  = RPT_W'(REPEAT_RATE);

    logic             tick_q_reg;
    logic             run_tick;
    logic             dayroll_reg;

    rpt_state_t       state_reg;
    logic [RPT_W-1:0] cnt_reg;
    logic             step_reg;
    logic             dir_up_reg;
    logic             lock_reg;
    logic [1:0]       sel_q_reg;

    logic             edit_up, edit_dn;
    logic [5:0]       s_q, m_q;
    logic [4:0]       h_q;
    logic             s_wrap, m_wrap, h_wrap;

    assign run_tick = tick1Hz & ~tick_q_reg & ~freeze;

    // Steps go to the field captured at the press; a later sel change aborts
    // the hold, so the pending step never lands on a different field.
    assign edit_up = step_reg & freeze & dir_up_reg;
    assign edit_dn = step_reg & freeze & ~dir_up_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q_reg  <= 1'b0;
            dayroll_reg <= 1'b0;
        end else begin
            tick_q_reg  <= tick1Hz;
            dayroll_reg <= h_wrap;
        end
    end

    // Hold-to-repeat FSM. lock_reg demands all buttons released before the
    // next press is accepted; it is armed out of reset and whenever a hold is
    // cut short by sel or freeze, so a button still held then never steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RPT_IDLE;
            cnt_reg    <= '0;
            step_reg   <= 1'b0;
            dir_up_reg <= 1'b0;
            lock_reg   <= 1'b1;
            sel_q_reg  <= SEL_NONE;
        end else begin
            step_reg <= 1'b0;
            if (!freeze) begin
                state_reg <= RPT_IDLE;
                lock_reg  <= inc | dec;
            end else begin
                case (state_reg)
                    RPT_IDLE: begin
                        if (lock_reg) begin
                            if (!inc && !dec)
                                lock_reg <= 1'b0;
                        end else if (sel != SEL_NONE && (inc ^ dec)) begin
                            step_reg   <= 1'b1;
                            dir_up_reg <= inc;
                            sel_q_reg  <= sel;
                            cnt_reg    <= DELAY_LD;
                            state_reg  <= RPT_WAIT;
                        end
                    end
                    RPT_WAIT, RPT_REPEAT: begin
                        if (sel != sel_q_reg) begin
                            state_reg <= RPT_IDLE;
                            lock_reg  <= 1'b1;
                        end else if ((inc && dec) || (dir_up_reg ? !inc : !dec)) begin
                            state_reg <= RPT_IDLE;
                        end else if (cnt_reg <= RPT_W'(1)) begin
                            // Counter reaches zero on this edge: steps are
                            // spaced exactly DELAY, then RATE, cycles apart.
                            step_reg  <= 1'b1;
                            cnt_reg   <= RATE_LD;
                            state_reg <= RPT_REPEAT;
                        end else begin
                            cnt_reg <= cnt_reg - RPT_W'(1);
                        end
                    end
                    default: state_reg <= RPT_IDLE;
                endcase
            end
        end
    end

    tc_field #(.MOD(MOD_S), .W(6)) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_up    (edit_up & (sel_q_reg == SEL_SEC)),
        .en_dn    (edit_dn & (sel_q_reg == SEL_SEC)),
        .carry_in (run_tick),
        .q        (s_q),
        .wrap_out (s_wrap)
    );

    tc_field #(.MOD(MOD_M), .W(6)) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_up    (edit_up & (sel_q_reg == SEL_MIN)),
        .en_dn    (edit_dn & (sel_q_reg == SEL_MIN)),
        .carry_in (s_wrap),
        .q        (m_q),
        .wrap_out (m_wrap)
    );

    tc_field #(.MOD(MOD_H), .W(5)) u_hour (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_up    (edit_up & (sel_q_reg == SEL_HOUR)),
        .en_dn    (edit_dn & (sel_q_reg == SEL_HOUR)),
        .carry_in (m_wrap),
        .q        (h_q),
        .wrap_out (h_wrap)
    );

    assign ss      = s_q;
    assign mm      = m_q;
    assign hh      = mode12 ? hour12(h_q) : h_q;
    assign pm      = mode12 & (h_q >= 5'd12);
    assign dayroll = dayroll_reg;

`ifdef TIMECOUNTER_ALARM_EN
    // Match against the values this tick is about to load; s_wrap already
    // implies a running tick and ss becoming 0.
    logic       alarm_hit_reg;
    logic [5:0] m_after;
    logic [4:0] h_after;

    assign m_after = m_wrap ? 6'd0 : m_q + 6'd1;
    assign h_after = h_wrap ? 5'd0 : (m_wrap ? h_q + 5'd1 : h_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alarm_hit_reg <= 1'b0;
        else
            alarm_hit_reg <= alarm_on & s_wrap & (m_after == alarm_mm) & (h_after == alarm_hh);
    end

    assign alarm_hit = alarm_hit_reg;
`endif

endmodule

// File: tb/tb_timecounter_rpt.sv
// tb_timecounter_rpt: directed stimulus with a snapshot scoreboard.
// The driver pushes hand-computed expected outputs; the monitor pops one
// entry per falling clock edge and compares it with the DUT outputs.
module tb_timecounter_rpt;
    import timecounter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick1Hz = 1'b0;
    logic       freeze = 1'b0;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic [1:0] sel = SEL_NONE;
    logic       mode12 = 1'b0;
    logic [5:0] ss, mm;
    logic [4:0] hh;
    logic       pm, dayroll;
    logic       al_hit;
`ifdef TIMECOUNTER_ALARM_EN
    logic       alarm_on = 1'b0;
    logic [4:0] alarm_hh = 5'd0;
    logic [5:0] alarm_mm = 6'd0;
`endif

    timecounter_rpt #(
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4),
        .RPT_W        (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick1Hz   (tick1Hz),
        .freeze    (freeze),
        .inc       (inc),
        .dec       (dec),
        .sel       (sel),
        .mode12    (mode12),
        .ss        (ss),
        .mm        (mm),
        .hh        (hh),
        .pm        (pm),
        .dayroll   (dayroll)
`ifdef TIMECOUNTER_ALARM_EN
        ,
        .alarm_on  (alarm_on),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm_hit (al_hit)
`endif
    );

`ifndef TIMECOUNTER_ALARM_EN
    assign al_hit = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    s, m, h, p, d, a, c;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   drc      = 0;

    task automatic cmp(input string nm, input string f, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, f, act, req);
        end
    endtask

    // Monitor: counts dayroll pulses and checks one snapshot per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (dayroll)
            drc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "ss", int'(ss), e.s);
            cmp(e.name, "mm", int'(mm), e.m);
            cmp(e.name, "hh", int'(hh), e.h);
            cmp(e.name, "pm", int'(pm), e.p);
            cmp(e.name, "dayroll", int'(dayroll), e.d);
            cmp(e.name, "dayroll_count", drc, e.c);
`ifdef TIMECOUNTER_ALARM_EN
            cmp(e.name, "alarm_hit", int'(al_hit), e.a);
`endif
            $display("TXN %s ss=%0d mm=%0d hh=%0d pm=%0d dayroll=%0d alarm=%0d",
                     e.name, ss, mm, hh, pm, dayroll, al_hit);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push an expected snapshot, then hold inputs until it has been sampled.
    task automatic expect_now(input string nm, input int s, input int m, input int h,
                              input int p, input int d, input int a, input int c);
        exp_t e;
        e.name = nm; e.s = s; e.m = m; e.h = h; e.p = p; e.d = d; e.a = a; e.c = c;
        exp_q.push_back(e);
        cyc(1);
    endtask

    // Returns one cycle after the edge, i.e. right after the counters update.
    task automatic do_tick();
        tick1Hz = 1'b1;
        cyc(1);
        tick1Hz = 1'b0;
    endtask

    task automatic hold(input bit up, input int n);
        if (up) inc = 1'b1; else dec = 1'b1;
        cyc(n);
        inc = 1'b0;
        dec = 1'b0;
        cyc(3);
    endtask

    task automatic tap(input bit up);
        hold(up, 2);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        cyc(2);
        expect_now("reset_24h", 0, 0, 0, 0, 0, 0, 0);
        mode12 = 1'b1;
        expect_now("reset_12h", 0, 0, 12, 0, 0, 0, 0);
        mode12 = 1'b0;
        rst_n  = 1'b1;
        cyc(2);

        // Running count: 90 ticks.
        repeat (90) begin
            do_tick();
            cyc(1);
        end
        expect_now("run_90", 30, 1, 0, 0, 0, 0, 0);
        sel = SEL_SEC;
        tap(1'b1);
        expect_now("run_inc_ignored", 30, 1, 0, 0, 0, 0, 0);
        sel = SEL_NONE;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        expect_now("reset_again", 0, 0, 0, 0, 0, 0, 0);

        // Preload 23:59:59 by decrement wrap, then roll the day.
        freeze = 1'b1;
        sel = SEL_SEC;  tap(1'b0);
        sel = SEL_MIN;  tap(1'b0);
        sel = SEL_HOUR; tap(1'b0);
        expect_now("preload", 59, 59, 23, 0, 0, 0, 0);
        freeze = 1'b0;
        sel = SEL_NONE;
        cyc(1);
        do_tick();
        expect_now("dayroll_hi", 0, 0, 0, 0, 1, 0, 1);
        expect_now("dayroll_lo", 0, 0, 0, 0, 0, 0, 1);

        // Seconds edit: taps, then a 20-cycle hold with auto-repeat.
        freeze = 1'b1;
        sel = SEL_SEC;
        tap(1'b0);
        tap(1'b0);
        expect_now("ss58", 58, 0, 0, 0, 0, 0, 1);
        hold(1'b1, 2);
        expect_now("inc_tap", 59, 0, 0, 0, 0, 0, 1);
        inc = 1'b1;
        cyc(9);
        expect_now("rpt_first", 0, 0, 0, 0, 0, 0, 1);
        expect_now("rpt_delay", 1, 0, 0, 0, 0, 0, 1);
        cyc(9);
        inc = 1'b0;
        cyc(3);
        expect_now("inc_hold20", 3, 0, 0, 0, 0, 0, 1);

        // Minutes edit, both buttons, dropped tick, sel none.
        sel = SEL_MIN;
        tap(1'b0);
        tap(1'b0);
        expect_now("mm_dec2", 3, 58, 0, 0, 0, 0, 1);
        inc = 1'b1;
        dec = 1'b1;
        cyc(6);
        inc = 1'b0;
        dec = 1'b0;
        cyc(3);
        expect_now("both_high", 3, 58, 0, 0, 0, 0, 1);
        do_tick();
        cyc(1);
        expect_now("frozen_tick", 3, 58, 0, 0, 0, 0, 1);
        sel = SEL_NONE;
        tap(1'b1);
        expect_now("sel_none", 3, 58, 0, 0, 0, 0, 1);

        // 12 h mapping.
        mode12 = 1'b1;
        expect_now("m12_h0", 3, 58, 12, 0, 0, 0, 1);
        sel = SEL_HOUR;
        repeat (12) tap(1'b1);
        expect_now("m12_h12", 3, 58, 12, 1, 0, 0, 1);
        tap(1'b1);
        expect_now("m12_h13", 3, 58, 1, 1, 0, 0, 1);
        mode12 = 1'b0;
        expect_now("m24_h13", 3, 58, 13, 0, 0, 0, 1);

        // Async reset during WAIT with inc held.
        inc = 1'b1;
        cyc(5);
        expect_now("hold_first", 3, 58, 14, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        expect_now("async_rst", 0, 0, 0, 0, 0, 0, 1);
        cyc(1);
        rst_n = 1'b1;
        cyc(12);
        expect_now("no_step_after_rst", 0, 0, 0, 0, 0, 0, 1);
        inc = 1'b0;
        cyc(3);
        tap(1'b1);
        expect_now("new_press", 0, 0, 1, 0, 0, 0, 1);

`ifdef TIMECOUNTER_ALARM_EN
        alarm_on = 1'b1;
        alarm_hh = 5'd0;
        alarm_mm = 6'd2;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        sel = SEL_MIN; tap(1'b1);
        sel = SEL_SEC; tap(1'b0);
        expect_now("alarm_pre", 59, 1, 0, 0, 0, 0, 1);
        freeze = 1'b0;
        sel = SEL_NONE;
        cyc(1);
        do_tick();
        expect_now("alarm_hi", 0, 2, 0, 0, 0, 1, 1);
        expect_now("alarm_lo", 0, 2, 0, 0, 0, 0, 1);
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
